mc_clkgen: RTL and testbench
============================

MC_CLKGEN -- requirements
Module: mc_clkgen

Interface
REQ-001 Parameter NCH, default 4: number of divided-clock channels, range 1..16.
REQ-002 Parameter DIV_W, default 16: divisor width in bits.
REQ-003 Parameter WDT_W, default 20: watchdog counter width in bits.
REQ-004 Parameter WDT_LIMIT, default 2**WDT_W-1: watchdog expiry count, range 1..2**WDT_W-1.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port clk_en, input, 1 bit: global run enable.
REQ-008 Port cfg_we, input, 1 bit: configuration write strobe, one write per cycle.
REQ-009 Port cfg_ch, input, $clog2(NCH) bits (minimum 1): target channel index.
REQ-010 Port cfg_div, input, DIV_W bits: divisor N.
REQ-011 Port cfg_en, input, 1 bit: channel enable value to write.
REQ-012 Port wdt_en, input, 1 bit: watchdog run enable.
REQ-013 Port wdt_kick, input, 1 bit: watchdog clear.
REQ-014 Port ch_clk, output, NCH bits: divided square clocks, one per channel.
REQ-015 Port ch_tick, output, NCH bits: one-cycle wrap pulses, one per channel.
REQ-016 Port wdt_bark, output, 1 bit: one-cycle expiry pulse.
REQ-017 Port wdt_expired, output, 1 bit: sticky expiry flag.

Function
REQ-018 Each channel SHALL hold three registers: active divisor, pending divisor, enable; and one counter, DIV_W bits.
REQ-019 Enabled channel, clk_en=1, N>=1: counter SHALL count 0..N-1 and then wrap; on the N-1 cycle the channel SHALL pulse ch_tick for one cycle and toggle ch_clk on the following edge, so the ch_clk period is 2N cycles.
REQ-020 N=1: ch_tick SHALL be high every cycle and ch_clk SHALL toggle every cycle.
REQ-021 clk_en=0: all counters and ch_clk SHALL hold their values and ch_tick SHALL be 0; counting SHALL resume from the held count.
REQ-022 Write to a running channel: the new divisor SHALL go to the pending register and become active on that channel's next wrap (glitch-free); a second write before that wrap overwrites the pending value.
REQ-023 Write to a stopped channel: the divisor SHALL become active immediately; the counter SHALL start at 0 on the next cycle.
REQ-024 Disable (cfg_en=0) with ch_clk low: the channel SHALL stop on the next cycle, with counter cleared.
REQ-025 Disable with ch_clk high: the channel SHALL keep running until its next toggle drives ch_clk low, then stop; no runt pulse is allowed.
REQ-026 cfg_div=0 with cfg_en=1 SHALL be treated as a disable.
REQ-027 A write with cfg_ch>=NCH SHALL be ignored.
REQ-028 Watchdog counter increments when wdt_en=1 and clk_en=1; it holds otherwise.
REQ-029 wdt_kick=1 SHALL clear the counter to 0 on the next cycle; kick wins over increment and over expiry in the same cycle.
REQ-030 When the counter reaches WDT_LIMIT: wdt_bark SHALL pulse for one cycle, wdt_expired SHALL set, and the counter SHALL saturate at WDT_LIMIT.
REQ-031 wdt_expired SHALL clear only on rst; a kick after expiry restarts the count but leaves the flag set.

Reset
REQ-032 While rst=1, all outputs SHALL be 0 on the next edge.
REQ-033 While rst=1, all counters SHALL be 0, all enables 0, and active and pending divisors 0.
REQ-034 rst SHALL override cfg_we, wdt_kick and clk_en; reset mid-period truncates ch_clk immediately.

Structure
REQ-035 Package mc_pkg SHALL hold the default values of NCH, DIV_W, WDT_W and WDT_LIMIT, plus a channel-config struct {en, div}.
REQ-036 Sub-module mc_div_ch SHALL implement one channel, instantiated NCH times by a generate loop.
REQ-037 The watchdog SHALL be implemented inline in mc_clkgen.

Verification
REQ-038 Reset release, write ch0 N=3 en=1 -> ch_tick[0] every 3 cycles; ch_clk[0] high 3 cycles, low 3 cycles.
REQ-039 ch1 running N=4, write N=2 mid-period -> the current period completes at 4, then the half-period is 2; no short pulse.
REQ-040 ch2 N=5, ch_clk high at count 1, disable -> ch_clk falls after count 4, then stays 0; counter reads 0.
REQ-041 clk_en low for 7 cycles mid-count -> ch_tick=0 and outputs frozen; the period resumes with exactly 7 cycles of extra delay.
REQ-042 WDT_LIMIT=10, wdt_en=1, no kick -> wdt_bark on the 10th count, wdt_expired=1; kick at count 9 -> no bark.
REQ-043 cfg_ch=NCH write, plus cfg_div=0 with en=1 -> no channel changes state, or the target channel stops, respectively.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared defaults and the channel write record for the clock generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_pkg;

  localparam int NCH_DEF       = 4;
  localparam int DIV_W_DEF     = 16;
  localparam int WDT_W_DEF     = 20;
  localparam int WDT_LIMIT_DEF = 2**WDT_W_DEF - 1;

  // Widest divisor a channel can accept; DIV_W must not exceed this.
  localparam int DIV_W_MAX = 32;

  // One configuration write as seen by a channel.
  typedef struct packed {
    logic                 en;
    logic [DIV_W_MAX-1:0] div;
  } ch_cfg_t;

endpackage

// File: rtl/mc_div_ch.sv
// One divided-clock channel: counts 0..N-1, ticks on N-1, toggles ch_clk at the wrap.
// Latency: ch_tick is combinational from state; ch_clk toggles on the edge after the tick.
// Backpressure: none; clk_en freezes the counter and ch_clk.
module mc_div_ch
  import mc_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    clk_en,
  input  logic    wr_vld,
  input  ch_cfg_t wr_cfg,
  output logic    ch_clk,
  output logic    ch_tick
);

  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] pend_div;
  logic             en;
  logic [DIV_W-1:0] cnt;

  logic             running;
  logic             wrap;
  logic             wr_go;
  logic [DIV_W-1:0] new_div;

  // A disabled channel keeps running while ch_clk is high so the high phase is never cut short.
  assign running = en || ch_clk;
  assign wrap    = running && clk_en && (cnt == act_div - DIV_W'(1));
  assign ch_tick = wrap;
  // A zero divisor cannot run, so it is folded into a disable.
  assign wr_go   = wr_cfg.en && (wr_cfg.div != '0);
  assign new_div = wr_cfg.div[DIV_W-1:0];

  // Counter, output level and divisor registers; config writes take priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_div  <= '0;
      pend_div <= '0;
      en       <= 1'b0;
      cnt      <= '0;
      ch_clk   <= 1'b0;
    end else begin
      if (wrap) begin
        cnt     <= '0;
        ch_clk  <= ~ch_clk;
        act_div <= pend_div;
      end else if (running && clk_en) begin
        cnt <= cnt + DIV_W'(1);
      end else if (!running) begin
        cnt <= '0;
      end

      if (wr_vld) begin
        if (wr_go) begin
          en       <= 1'b1;
          pend_div <= new_div;
          // Stopped channel: start clean with the new divisor straight away.
          if (!running) begin
            act_div <= new_div;
            cnt     <= '0;
          end
        end else begin
          en <= 1'b0;
          // Low phase: stop now; high phase: let it drain to the next falling toggle.
          if (!ch_clk) begin
            cnt    <= '0;
            ch_clk <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mc_clkgen.sv
// Multi-channel programmable clock divider with a kickable watchdog.
// Latency: config writes land on the next edge; divisor changes on a running channel wait for its wrap.
// Backpressure: none; one config write per cycle, out-of-range channel writes are dropped.
module mc_clkgen
  import mc_pkg::*;
#(
  parameter int  NCH       = NCH_DEF,
  parameter int  DIV_W     = DIV_W_DEF,
  parameter int  WDT_W     = WDT_W_DEF,
  parameter int  WDT_LIMIT = 2**WDT_W - 1,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  input  logic             wdt_en,
  input  logic             wdt_kick,
  output logic [NCH-1:0]   ch_clk,
  output logic [NCH-1:0]   ch_tick,
  output logic             wdt_bark,
  output logic             wdt_expired
);

  localparam logic [WDT_W-1:0] WDT_MAX  = WDT_W'(WDT_LIMIT);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_LIMIT - 1);

  ch_cfg_t          wr_cfg;
  logic [WDT_W-1:0] wdt_cnt;

  assign wr_cfg = '{en: cfg_en, div: DIV_W_MAX'(cfg_div)};

  // Indices at or above NCH match no channel, so such writes fall away.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic hit;
    assign hit = cfg_we && (cfg_ch == CH_W'(i));

    mc_div_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .wr_vld (hit),
      .wr_cfg (wr_cfg),
      .ch_clk (ch_clk[i]),
      .ch_tick(ch_tick[i])
    );
  end

  // Watchdog: kick clears, otherwise count up to the limit and saturate; bark once on arrival.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt     <= '0;
      wdt_bark    <= 1'b0;
      wdt_expired <= 1'b0;
    end else begin
      wdt_bark <= 1'b0;
      if (wdt_kick) begin
        wdt_cnt <= '0;
      end else if (wdt_en && clk_en && (wdt_cnt != WDT_MAX)) begin
        wdt_cnt <= wdt_cnt + WDT_W'(1);
        if (wdt_cnt == WDT_LAST) begin
          wdt_bark    <= 1'b1;
          wdt_expired <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_clkgen.sv
// Self-checking bench for mc_clkgen: directed scenarios then random traffic against a countdown model.
// Latency: one check pass per clock, inputs driven and outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_mc_clkgen;

  localparam int NCH       = 3;
  localparam int DIV_W     = 8;
  localparam int WDT_W     = 8;
  localparam int WDT_LIMIT = 10;
  localparam int CH_W      = 2;

  logic             clk = 1'b0;
  logic             rst, clk_en, cfg_we, cfg_en, wdt_en, wdt_kick;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [NCH-1:0]   ch_clk, ch_tick;
  logic             wdt_bark, wdt_expired;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  mc_clkgen #(
    .NCH(NCH), .DIV_W(DIV_W), .WDT_W(WDT_W), .WDT_LIMIT(WDT_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_en(cfg_en), .wdt_en(wdt_en), .wdt_kick(wdt_kick),
    .ch_clk(ch_clk), .ch_tick(ch_tick), .wdt_bark(wdt_bark), .wdt_expired(wdt_expired)
  );

  // Reference model: mode 0 off, 1 running, 2 finishing a high phase before stopping.
  // left = cycles remaining in the current half period, half = its length, nxt = queued divisor.
  int m_mode[NCH], m_lvl[NCH], m_left[NCH], m_half[NCH], m_nxt[NCH];
  int m_wc, m_bark, m_exp;

  // Observations of the DUT outputs for the directed timing checks.
  int obs_last[NCH], obs_gap[NCH], tick_cnt[NCH], seg_start[NCH];
  int seg_q[NCH][$];
  logic [NCH-1:0] prev_clk;
  int bark_cnt, bark_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_mode[i] = 0; m_lvl[i] = 0; m_left[i] = 0; m_half[i] = 0; m_nxt[i] = 0;
      end else begin
        int pmode, plvl;
        pmode = m_mode[i];
        plvl  = m_lvl[i];
        if (pmode != 0 && clk_en) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_lvl[i]  = 1 - m_lvl[i];
            m_half[i] = m_nxt[i];
            m_left[i] = m_half[i];
            if (pmode == 2) m_mode[i] = 0;
          end
        end
        if (cfg_we && int'(cfg_ch) == i) begin
          if (cfg_en && cfg_div != 0) begin
            if (pmode == 0) begin
              m_half[i] = int'(cfg_div);
              m_left[i] = int'(cfg_div);
              m_lvl[i]  = 0;
            end
            m_nxt[i]  = int'(cfg_div);
            m_mode[i] = 1;
          end else if (pmode != 0) begin
            if (plvl == 0) begin
              m_mode[i] = 0;
              m_lvl[i]  = 0;
            end else begin
              m_mode[i] = (m_lvl[i] == 0) ? 0 : 2;
            end
          end
        end
      end
    end
    if (rst) begin
      m_wc = 0; m_bark = 0; m_exp = 0;
    end else begin
      m_bark = 0;
      if (wdt_kick) m_wc = 0;
      else if (wdt_en && clk_en && m_wc < WDT_LIMIT) begin
        m_wc++;
        if (m_wc == WDT_LIMIT) begin
          m_bark = 1;
          m_exp  = 1;
        end
      end
    end
  endtask

  // One clock: compare outputs under the currently applied inputs, advance the model, move to next falling edge.
  task automatic step();
    #1;
    for (int i = 0; i < NCH; i++) begin
      int exp_tick;
      exp_tick = (clk_en && m_mode[i] != 0 && m_left[i] == 1) ? 1 : 0;
      chk($sformatf("ch_clk[%0d]@%0d", i, cyc_n), ch_clk[i], m_lvl[i]);
      chk($sformatf("ch_tick[%0d]@%0d", i, cyc_n), ch_tick[i], exp_tick);
      if (ch_tick[i] === 1'b1) begin
        obs_gap[i]  = cyc_n - obs_last[i];
        obs_last[i] = cyc_n;
        tick_cnt[i]++;
      end
      if (ch_clk[i] !== prev_clk[i]) begin
        seg_q[i].push_back(cyc_n - seg_start[i]);
        seg_start[i] = cyc_n;
        prev_clk[i]  = ch_clk[i];
      end
    end
    chk($sformatf("wdt_bark@%0d", cyc_n), wdt_bark, m_bark);
    chk($sformatf("wdt_expired@%0d", cyc_n), wdt_expired, m_exp);
    if (wdt_bark === 1'b1) begin
      bark_cnt++;
      bark_cyc = cyc_n;
    end
    model_update();
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int ch, input int dv, input logic en);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = DIV_W'(dv);
    cfg_en  = en;
    step();
    cfg_we  = 1'b0;
  endtask

  initial begin
    int idx, sz, t2, b0, s;
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0; m_lvl[i] = 0; m_left[i] = 0; m_half[i] = 0; m_nxt[i] = 0;
      obs_last[i] = 0; obs_gap[i] = 0; tick_cnt[i] = 0; seg_start[i] = 0;
    end
    m_wc = 0; m_bark = 0; m_exp = 0;
    prev_clk = '0; bark_cnt = 0; bark_cyc = 0;
    rst = 1'b1; clk_en = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    cfg_en = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
    @(negedge clk);
    idle(3);
    chk("reset ch_clk", ch_clk, 0);
    chk("reset ch_tick", ch_tick, 0);
    chk("reset wdt_bark", wdt_bark, 0);
    chk("reset wdt_expired", wdt_expired, 0);
    rst = 1'b0;
    idle(2);

    // ch0 N=3: tick every 3 cycles, 3 high / 3 low.
    wr(0, 3, 1'b1);
    idle(20);
    chk("n3 tick gap", obs_gap[0], 3);
    chk("n3 half a", seg_q[0][$], 3);
    chk("n3 half b", seg_q[0][$-1], 3);

    // ch1 N=4, rewritten to N=2 at count 1 of the high phase.
    wr(1, 4, 1'b1);
    idle(5);
    wr(1, 2, 1'b1);
    idx = seg_q[1].size();
    idle(12);
    chk("retime current half", seg_q[1][idx], 4);
    chk("retime next half", seg_q[1][idx+1], 2);
    chk("retime following half", seg_q[1][idx+2], 2);

    // ch1 N=1: toggles every cycle.
    wr(1, 1, 1'b1);
    idle(6);
    chk("n1 tick gap", obs_gap[1], 1);
    chk("n1 half", seg_q[1][$], 1);

    // ch2 N=5 disabled at count 1 while high: full high phase, then silence.
    wr(2, 5, 1'b1);
    idle(6);
    wr(2, 0, 1'b0);
    sz = seg_q[2].size();
    idle(12);
    chk("drain high len", seg_q[2][$], 5);
    chk("drain one fall", seg_q[2].size(), sz + 1);
    chk("drain clk low", ch_clk[2], 0);

    // cfg_div=0 with en=1 disables ch2 the same way.
    wr(2, 4, 1'b1);
    idle(6);
    wr(2, 0, 1'b1);
    idle(10);
    chk("div0 high len", seg_q[2][$], 4);
    chk("div0 clk low", ch_clk[2], 0);

    // Out-of-range channel write changes nothing.
    t2 = tick_cnt[2];
    wr(3, 1, 1'b1);
    idle(10);
    chk("bad ch no ticks", tick_cnt[2] - t2, 0);
    chk("bad ch ch0 gap", obs_gap[0], 3);

    // clk_en low for 7 cycles right after ch0's count 0.
    for (int i = 0; i < 10 && ch_tick[0] !== 1'b1; i++) step();
    chk("align on ch0 tick", ch_tick[0], 1);
    step();
    step();
    clk_en = 1'b0;
    idle(7);
    clk_en = 1'b1;
    step();
    step();
    chk("stall tick gap", obs_gap[0], 10);

    // Watchdog: kick at count 9 suppresses the bark.
    wdt_kick = 1'b1;
    step();
    wdt_kick = 1'b0;
    wdt_en = 1'b1;
    b0 = bark_cnt;
    idle(9);
    wdt_kick = 1'b1;
    step();
    wdt_kick = 1'b0;
    idle(8);
    chk("kick9 no bark", bark_cnt - b0, 0);
    chk("kick9 not expired", wdt_expired, 0);
    // Unkicked: bark on the 10th count, saturate, sticky flag.
    wdt_kick = 1'b1;
    step();
    wdt_kick = 1'b0;
    s = cyc_n;
    idle(14);
    chk("bark timing", bark_cyc - s, 10);
    chk("bark once", bark_cnt - b0, 1);
    chk("expired set", wdt_expired, 1);
    wdt_kick = 1'b1;
    step();
    wdt_kick = 1'b0;
    idle(2);
    chk("expired sticky", wdt_expired, 1);

    // Random traffic, every cycle checked against the model.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(199) == 0);
      clk_en   = ($urandom_range(99) < 85);
      cfg_we   = ($urandom_range(99) < 15);
      cfg_ch   = CH_W'($urandom_range(3));
      cfg_div  = DIV_W'($urandom_range(6));
      cfg_en   = ($urandom_range(99) < 80);
      wdt_en   = ($urandom_range(99) < 70);
      wdt_kick = ($urandom_range(99) < 4);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
